// File: rtl/hex_display_ctrl.sv
// rtl/hex_display_ctrl.sv - Avalon-MM hex digit register bank with 7-segment decode, blink and blank
module hex_display_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int BLINK_DIV  = 25000000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [2:0]              address,
  input  logic                    chipselect,
  input  logic                    write_n,
  input  logic [31:0]             writedata,
  output logic [31:0]             readdata,
  output logic [4*NUM_DIGITS-1:0] out_port,
  output logic [7*NUM_DIGITS-1:0] seg_out
);

  localparam int DW = 4 * NUM_DIGITS;
  localparam int SW = 7 * NUM_DIGITS;
  localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(BLINK_DIV - 1);
  localparam logic [SW-1:0] SEG_OFF = ACTIVE_LOW ? {SW{1'b1}} : {SW{1'b0}};

  logic [DW-1:0]         data;
  logic [NUM_DIGITS-1:0] en;
  logic [NUM_DIGITS-1:0] blink;
  logic                  blank;
  logic [CW-1:0]         cnt;
  logic                  phase;
  logic [SW-1:0]         seg_next;

  logic wr;
  logic wr_data;
  logic wr_ctrl;
  logic wr_set;
  logic wr_clr;
  logic sync_req;
  logic unused_wd;

  assign wr       = chipselect & ~write_n;
  assign wr_data  = wr & (address == 3'd0);
  assign wr_ctrl  = wr & (address == 3'd1);
  assign wr_set   = wr & (address == 3'd2);
  assign wr_clr   = wr & (address == 3'd3);
  assign sync_req = wr_ctrl & writedata[17];
  assign unused_wd = ^writedata;

  assign out_port = data;

  // Active-high gfedcba pattern for one hex nibble; lit=0 yields a dark digit
  function automatic logic [6:0] digit_seg(input logic [3:0] nib, input logic lit);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return lit ? s : 7'h00;
  endfunction

  // DATA register: direct write, atomic bit set and bit clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data <= '0;
    end else if (wr_data) begin
      data <= writedata[DW-1:0];
    end else if (wr_set) begin
      data <= data | writedata[DW-1:0];
    end else if (wr_clr) begin
      data <= data & ~writedata[DW-1:0];
    end
  end

  // CTRL fields; SYNC is not stored, it only acts on the blink timer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en    <= '1;
      blink <= '0;
      blank <= 1'b0;
    end else if (wr_ctrl) begin
      en    <= writedata[NUM_DIGITS-1:0];
      blink <= writedata[8 +: NUM_DIGITS];
      blank <= writedata[16];
    end
  end

  // Free-running blink timer; a SYNC write restarts it and wins over the wrap
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (sync_req) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (cnt == CNT_MAX) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt   <= cnt + CW'(1);
    end
  end

  // Per-digit visibility and decode from the current register state
  always_comb begin
    seg_next = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (ACTIVE_LOW)
        seg_next[7*i +: 7] = ~digit_seg(data[4*i +: 4], en[i] & ~blank & ~(blink[i] & phase));
      else
        seg_next[7*i +: 7] = digit_seg(data[4*i +: 4], en[i] & ~blank & ~(blink[i] & phase));
    end
  end

  // Segment output register, one cycle behind the state that drives it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg_out <= SEG_OFF;
    end else begin
      seg_out <= seg_next;
    end
  end

  // Zero-latency read mux; no side effects
  always_comb begin
    readdata = '0;
    if (chipselect) begin
      case (address)
        3'd0: readdata[DW-1:0] = data;
        3'd1: begin
          readdata[NUM_DIGITS-1:0]   = en;
          readdata[8 +: NUM_DIGITS]  = blink;
          readdata[16]               = blank;
        end
        3'd4: readdata[0] = phase;
        default: readdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// tb/tb_hex_display_ctrl.sv - self-checking bench for hex_display_ctrl
module tb_hex_display_ctrl;

  localparam int N = 4;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic [15:0] out_port;
  logic [27:0] seg_out;

  int vectors = 0;
  int miscompares = 0;

  hex_display_ctrl #(.NUM_DIGITS(N), .BLINK_DIV(D), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .out_port(out_port), .seg_out(seg_out)
  );

  always #5 clk = ~clk;

  localparam bit [6:0] DEC [0:15] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference state: registers as plain integers, blink phase derived from edges since restart
  int unsigned m_data = 0;
  int unsigned m_en = 4'hF;
  int unsigned m_blink = 0;
  int unsigned m_blank = 0;
  int unsigned m_ticks = 0;
  logic [27:0] m_seg = 28'hFFFFFFF;

  function automatic int unsigned m_phase();
    return (m_ticks / D) % 2;
  endfunction

  function automatic logic [27:0] m_seg_of();
    logic [27:0] s;
    s = '0;
    for (int i = 0; i < N; i++) begin
      int unsigned nib;
      bit off;
      logic [6:0] pat;
      nib = (m_data >> (4 * i)) & 4'hF;
      off = (((m_en >> i) & 1) == 0) || (m_blank != 0) || ((((m_blink >> i) & 1) != 0) && (m_phase() == 1));
      pat = off ? 7'h00 : DEC[nib];
      s[7*i +: 7] = ~pat;
    end
    return s;
  endfunction

  function automatic logic [31:0] m_read();
    if (!chipselect) return 32'd0;
    case (address)
      3'd0: return m_data;
      3'd1: return m_en | (m_blink << 8) | (m_blank << 16);
      3'd4: return m_phase();
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_data = 0; m_en = 4'hF; m_blink = 0; m_blank = 0; m_ticks = 0; m_seg = 28'hFFFFFFF;
    end else begin
      m_seg = m_seg_of();
      if (chipselect && !write_n && address == 3'd1 && writedata[17]) m_ticks = 0;
      else m_ticks = (m_ticks + 1) % (2 * D);
      if (chipselect && !write_n) begin
        case (address)
          3'd0: m_data = writedata & 32'hFFFF;
          3'd1: begin
            m_en    = writedata & 32'hF;
            m_blink = (writedata >> 8) & 32'hF;
            m_blank = (writedata >> 16) & 32'h1;
          end
          3'd2: m_data = m_data | (writedata & 32'hFFFF);
          3'd3: m_data = m_data & ~writedata & 32'hFFFF;
          default: ;
        endcase
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle compare against the reference on the falling edge
  always @(negedge clk) begin
    check("out_port", {16'd0, out_port}, m_data);
    check("seg_out", {4'd0, seg_out}, {4'd0, m_seg});
    check("readdata", readdata, m_read());
  end

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input string name, input logic [2:0] a, input logic [31:0] exp);
    @(posedge clk); #1;
    address = a; chipselect = 1'b1; write_n = 1'b1;
    #2 check(name, readdata, exp);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 check("reset_seg", {4'd0, seg_out}, 32'h0FFFFFFF);
    check("reset_out_port", {16'd0, out_port}, 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("first_zero", {4'd0, seg_out}, 32'h08102040);
    bus_read("rd_data_rst", 3'd0, 32'd0);
    bus_read("rd_ctrl_rst", 3'd1, 32'h0000000F);

    bus_write(3'd0, 32'h0000A5F3);
    check("out_port_same_edge", {16'd0, out_port}, 32'h0000A5F3);
    @(posedge clk); #1;
    check("seg_a5f3", {4'd0, seg_out}, 32'h01048730);
    bus_read("rd_data_a5f3", 3'd0, 32'h0000A5F3);

    bus_write(3'd0, 32'h00001234);
    bus_write(3'd2, 32'h000000F0);
    bus_read("set", 3'd0, 32'h000012F4);
    bus_write(3'd3, 32'h0000000F);
    bus_read("clr", 3'd0, 32'h000012F0);
    bus_read("rd_addr2", 3'd2, 32'd0);
    bus_read("rd_addr3", 3'd3, 32'd0);

    bus_write(3'd1, 32'hFFFCF00D);
    bus_read("ctrl_masked", 3'd1, 32'h0000000D);
    check("digit1_off", {25'd0, seg_out[13:7]}, 32'h7F);
    bus_write(3'd1, 32'h0001000D);
    @(posedge clk); #1;
    check("blank_all", {4'd0, seg_out}, 32'h0FFFFFFF);

    bus_write(3'd1, 32'h0002010F);
    repeat (2) @(posedge clk);
    #1 address = 3'd4; chipselect = 1'b1; write_n = 1'b1;
    #1 check("phase_pre_sync", readdata, 32'd0);
    bus_write(3'd1, 32'h0002010F);
    address = 3'd4; chipselect = 1'b1;
    #1 check("sync_no_toggle", readdata, 32'd0);
    repeat (3) @(posedge clk);
    #1 check("phase_still0", readdata, 32'd0);
    @(posedge clk); #1;
    check("phase_toggle", readdata, 32'd1);
    @(posedge clk); #1;
    check("digit0_blinked", {25'd0, seg_out[6:0]}, 32'h7F);
    check("digit1_steady", {25'd0, seg_out[13:7]}, 32'h0E);
    repeat (12) @(posedge clk);

    @(posedge clk); #3;
    reset_n = 1'b0;
    #1 check("async_seg", {4'd0, seg_out}, 32'h0FFFFFFF);
    check("async_out_port", {16'd0, out_port}, 32'd0);
    address = 3'd1; chipselect = 1'b1;
    #1 check("async_ctrl", readdata, 32'h0000000F);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    check("rerelease_zero", {4'd0, seg_out}, 32'h08102040);
    repeat (4) @(posedge clk);
    #1 $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
